// File: rtl/maple_frame_pattern_decoder.sv
// -----------------------------------------------------------------------------
// maple_frame_pattern_decoder
//
// Recognises Maple bus framing patterns from single-cycle line edge strobes.
//   Start pattern: SDCKA held low while SDCKB falls START_PULSES times.
//   End pattern  : SDCKB held low while SDCKA falls END_PULSES times.
// A window opens on the falling edge of the held line and closes on its rising
// edge. At close, the number of counted pulses is classified: too few pulses is
// ordinary data activity, the exact count is a frame event, anything else is a
// malformed pattern. A watchdog aborts windows that stay open too long.
//
// Ports
//   aclk            in   sole clock
//   areset          in   asynchronous active-high reset
//   en              in   decoder enable; low holds IDLE with everything cleared
//   sdcka_posedge   in   one-cycle strobe, SDCKA rising edge
//   sdcka_negedge   in   one-cycle strobe, SDCKA falling edge
//   sdckb_posedge   in   one-cycle strobe, SDCKB rising edge
//   sdckb_negedge   in   one-cycle strobe, SDCKB falling edge
//   start_frame     out  one-cycle pulse, valid start pattern
//   end_frame       out  one-cycle pulse, valid end pattern
//   start_error     out  one-cycle pulse, malformed start window
//   end_error       out  one-cycle pulse, malformed end window
//   timeout         out  one-cycle pulse, window exceeded TIMEOUT cycles
//   in_frame        out  level, high between accepted start and end/error/timeout
// -----------------------------------------------------------------------------
module maple_frame_pattern_decoder #(
  parameter int START_PULSES = 4,
  parameter int END_PULSES   = 2,
  parameter int IGNORE_BELOW = 2,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT      = 1024,
  parameter int TO_W         = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  input  logic sdcka_posedge,
  input  logic sdcka_negedge,
  input  logic sdckb_posedge,
  input  logic sdckb_negedge,
  output logic start_frame,
  output logic end_frame,
  output logic start_error,
  output logic end_error,
  output logic timeout,
  output logic in_frame
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_START = 3'b010,
    S_END   = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_PULSES);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(END_PULSES);
  localparam logic [CNT_W-1:0] CNT_IGN   = CNT_W'(IGNORE_BELOW);

  localparam logic [TO_W-1:0]  WD_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]  WD_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  WD_MAX    = {TO_W{1'b1}};
  localparam bit               WD_EN     = (TIMEOUT != 0);
  // Expiry is detected one count early so the pulse lands at entry+TIMEOUT+1.
  localparam logic [TO_W-1:0]  WD_LAST   = WD_EN ? TO_W'(TIMEOUT - 1) : WD_ZERO;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_wd;
  logic             r_start_frame;
  logic             r_end_frame;
  logic             r_start_error;
  logic             r_end_error;
  logic             r_timeout;
  logic             r_in_frame;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [TO_W-1:0]  w_wd;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [TO_W-1:0]  w_wd_inc;
  logic             w_expire;
  logic             w_start_frame;
  logic             w_end_frame;
  logic             w_start_error;
  logic             w_end_error;
  logic             w_timeout;
  logic             w_in_frame;

  // Saturating increments; the watchdog saturates too so a disabled watchdog
  // can never wrap into a spurious expiry.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_wd_inc  = (r_wd == WD_MAX) ? r_wd : r_wd + WD_ONE;
  assign w_expire  = WD_EN && (r_wd == WD_LAST);

  // Next-state, counter and event decode.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_wd          = r_wd;
    w_start_frame = 1'b0;
    w_end_frame   = 1'b0;
    w_start_error = 1'b0;
    w_end_error   = 1'b0;
    w_timeout     = 1'b0;
    w_in_frame    = r_in_frame;

    if (!en) begin
      w_state    = S_IDLE;
      w_cnt      = CNT_ZERO;
      w_wd       = WD_ZERO;
      w_in_frame = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt = CNT_ZERO;
          w_wd  = WD_ZERO;
          // Both falling edges together cannot be attributed to either pattern.
          if (sdcka_negedge && !sdckb_negedge) begin
            w_state = S_START;
          end else if (sdckb_negedge && !sdcka_negedge) begin
            w_state = S_END;
          end else begin
            w_state = S_IDLE;
          end
        end

        S_START: begin
          // Close takes priority over both the watchdog and a coincident pulse.
          if (sdcka_posedge) begin
            w_state = S_IDLE;
            w_cnt   = CNT_ZERO;
            w_wd    = WD_ZERO;
            if (r_cnt >= CNT_IGN) begin
              if (r_cnt == CNT_START) begin
                w_start_frame = 1'b1;
                w_in_frame    = 1'b1;
              end else begin
                w_start_error = 1'b1;
                w_in_frame    = 1'b0;
              end
            end else begin
              w_in_frame = r_in_frame;
            end
          end else if (w_expire) begin
            w_state    = S_IDLE;
            w_cnt      = CNT_ZERO;
            w_wd       = WD_ZERO;
            w_timeout  = 1'b1;
            w_in_frame = 1'b0;
          end else begin
            w_wd = w_wd_inc;
            if (sdckb_negedge) begin
              w_cnt = w_cnt_inc;
            end else begin
              w_cnt = r_cnt;
            end
          end
        end

        S_END: begin
          if (sdckb_posedge) begin
            w_state = S_IDLE;
            w_cnt   = CNT_ZERO;
            w_wd    = WD_ZERO;
            if (r_cnt >= CNT_IGN) begin
              // An end pattern is reported even outside a frame.
              if (r_cnt == CNT_END) begin
                w_end_frame = 1'b1;
              end else begin
                w_end_error = 1'b1;
              end
              w_in_frame = 1'b0;
            end else begin
              w_in_frame = r_in_frame;
            end
          end else if (w_expire) begin
            w_state    = S_IDLE;
            w_cnt      = CNT_ZERO;
            w_wd       = WD_ZERO;
            w_timeout  = 1'b1;
            w_in_frame = 1'b0;
          end else begin
            w_wd = w_wd_inc;
            if (sdcka_negedge) begin
              w_cnt = w_cnt_inc;
            end else begin
              w_cnt = r_cnt;
            end
          end
        end

        default: begin
          w_state    = S_IDLE;
          w_cnt      = CNT_ZERO;
          w_wd       = WD_ZERO;
          w_in_frame = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_cnt         <= CNT_ZERO;
      r_wd          <= WD_ZERO;
      r_start_frame <= 1'b0;
      r_end_frame   <= 1'b0;
      r_start_error <= 1'b0;
      r_end_error   <= 1'b0;
      r_timeout     <= 1'b0;
      r_in_frame    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_wd          <= w_wd;
      r_start_frame <= w_start_frame;
      r_end_frame   <= w_end_frame;
      r_start_error <= w_start_error;
      r_end_error   <= w_end_error;
      r_timeout     <= w_timeout;
      r_in_frame    <= w_in_frame;
    end
  end

  assign start_frame = r_start_frame;
  assign end_frame   = r_end_frame;
  assign start_error = r_start_error;
  assign end_error   = r_end_error;
  assign timeout     = r_timeout;
  assign in_frame    = r_in_frame;

endmodule

// File: tb/tb_maple_frame_pattern_decoder.sv
// Testbench for maple_frame_pattern_decoder. The main instance uses default
// parameters; a second instance with TIMEOUT=16 shares the stimulus and is
// only examined by the watchdog scenario.
module tb_maple_frame_pattern_decoder;

  // Strobe vector layout for step(): {a_pos, a_neg, b_pos, b_neg}
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] A_P  = 4'b1000;
  localparam logic [3:0] A_N  = 4'b0100;
  localparam logic [3:0] B_P  = 4'b0010;
  localparam logic [3:0] B_N  = 4'b0001;

  localparam int MAXC = 255;  // 2^CNT_W-1 with CNT_W=8

  logic aclk = 1'b0;
  logic areset, en, a_pos, a_neg, b_pos, b_neg;
  logic sf, ef, se, ee, to, inf;
  logic sf2, ef2, se2, ee2, to2, inf2;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  maple_frame_pattern_decoder dut (
    .aclk(aclk), .areset(areset), .en(en),
    .sdcka_posedge(a_pos), .sdcka_negedge(a_neg),
    .sdckb_posedge(b_pos), .sdckb_negedge(b_neg),
    .start_frame(sf), .end_frame(ef), .start_error(se), .end_error(ee),
    .timeout(to), .in_frame(inf)
  );

  maple_frame_pattern_decoder #(.TIMEOUT(16)) dut_to (
    .aclk(aclk), .areset(areset), .en(en),
    .sdcka_posedge(a_pos), .sdcka_negedge(a_neg),
    .sdckb_posedge(b_pos), .sdckb_negedge(b_neg),
    .start_frame(sf2), .end_frame(ef2), .start_error(se2), .end_error(ee2),
    .timeout(to2), .in_frame(inf2)
  );

  // {start_frame, end_frame, start_error, end_error, timeout, in_frame}
  function automatic logic [5:0] outs();
    return {sf, ef, se, ee, to, inf};
  endfunction

  // Event pulses must be mutually exclusive on both instances every cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      checks++;
      if (($countones({sf, ef, se, ee, to}) > 1) || ($countones({sf2, ef2, se2, ee2, to2}) > 1)) begin
        errors++;
        $display("FAIL onehot t=%0t got %b / %b want at most one pulse", $time,
                 {sf, ef, se, ee, to}, {sf2, ef2, se2, ee2, to2});
      end
    end
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_time_limit expired, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

  // Drive strobes for one cycle; returns #1 after the edge that sampled them.
  task automatic step(input logic [3:0] s);
    {a_pos, a_neg, b_pos, b_neg} = s;
    @(posedge aclk);
    #1;
    {a_pos, a_neg, b_pos, b_neg} = NONE;
  endtask

  task automatic send_start(input int n);
    step(A_N);
    for (int i = 0; i < n; i++) step(B_N);
    step(A_P);
  endtask

  task automatic send_end(input int n);
    step(B_N);
    for (int i = 0; i < n; i++) step(A_N);
    step(B_P);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    en = 1'b1;
    {a_pos, a_neg, b_pos, b_neg} = NONE;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    step(NONE);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    en = 1'b1;
    {a_pos, a_neg, b_pos, b_neg} = NONE;
    #1;
    checks++;
    if ({outs(), sf2, ef2, se2, ee2, to2, inf2} !== 12'b0) begin
      errors++;
      $display("FAIL reset_async got %b %b want all zero", outs(), {sf2, ef2, se2, ee2, to2, inf2});
    end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (outs() !== 6'b000000) begin
      errors++;
      $display("FAIL reset_held got %b want 000000", outs());
    end
    areset = 1'b0;
    step(NONE);
  endtask

  task automatic test_valid_frame();
    send_start(4);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL valid_start got %b want 100001", outs()); end
    step(NONE);
    checks++;
    if (outs() !== 6'b000001) begin errors++; $display("FAIL start_one_cycle got %b want 000001", outs()); end
    send_end(2);
    checks++;
    if (outs() !== 6'b010000) begin errors++; $display("FAIL valid_end got %b want 010000", outs()); end
    step(NONE);
    checks++;
    if (outs() !== 6'b000000) begin errors++; $display("FAIL end_one_cycle got %b want 000000", outs()); end
  endtask

  task automatic test_ignore_and_errors();
    int          n_start[4]  = '{2, 3, 5, 4};
    logic [5:0]  exp_start[4] = '{6'b001000, 6'b001000, 6'b001000, 6'b100001};
    send_end(0);
    checks++;
    if (outs() !== 6'b000000) begin errors++; $display("FAIL end_ignore0 got %b want 000000", outs()); end
    send_end(1);
    checks++;
    if (outs() !== 6'b000000) begin errors++; $display("FAIL end_ignore1 got %b want 000000", outs()); end
    send_start(4);
    send_start(4);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL start_resync got %b want 100001", outs()); end
    send_start(1);
    checks++;
    if (outs() !== 6'b000001) begin errors++; $display("FAIL start_ignore1 got %b want 000001", outs()); end
    send_end(3);
    checks++;
    if (outs() !== 6'b000100) begin errors++; $display("FAIL end_error3 got %b want 000100", outs()); end
    send_start(4);
    for (int i = 0; i < 4; i++) begin
      send_start(n_start[i]);
      checks++;
      if (outs() !== exp_start[i]) begin
        errors++;
        $display("FAIL start_count%0d got %b want %b", n_start[i], outs(), exp_start[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(A_N);
    for (int i = 0; i < 15; i++) begin
      step(NONE);
      checks++;
      if (to2 !== 1'b0) begin errors++; $display("FAIL timeout_early cycle %0d got %b want 0", i + 2, to2); end
    end
    step(NONE);
    checks++;
    if ({sf2, ef2, se2, ee2, to2} !== 5'b00001) begin
      errors++;
      $display("FAIL timeout_at_17 got %b want 00001", {sf2, ef2, se2, ee2, to2});
    end
    step(NONE);
    checks++;
    if (to2 !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle got %b want 0", to2); end
    // Close exactly on the expiry cycle: classification wins.
    step(A_N);
    for (int i = 0; i < 4; i++) step(B_N);
    for (int i = 0; i < 11; i++) step(NONE);
    step(A_P);
    checks++;
    if ({sf2, ef2, se2, ee2, to2, inf2} !== 6'b100001) begin
      errors++;
      $display("FAIL close_on_expiry got %b want 100001", {sf2, ef2, se2, ee2, to2, inf2});
    end
    do_reset();
  endtask

  task automatic test_saturation();
    send_start(300);
    checks++;
    if (outs() !== 6'b001000) begin errors++; $display("FAIL sat_start300 got %b want 001000", outs()); end
    send_start(260);
    checks++;
    if (outs() !== 6'b001000) begin errors++; $display("FAIL sat_start260 got %b want 001000", outs()); end
    send_end(258);
    checks++;
    if (outs() !== 6'b000100) begin errors++; $display("FAIL sat_end258 got %b want 000100", outs()); end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    send_start(4);
    step(B_N);
    step(A_N);
    checks++;
    if (outs() !== 6'b000001) begin errors++; $display("FAIL mid_window_pre got %b want 000001", outs()); end
    areset = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b000000) begin errors++; $display("FAIL mid_window_async got %b want 000000", outs()); end
    step(A_N);
    checks++;
    if (outs() !== 6'b000000) begin errors++; $display("FAIL mid_window_held got %b want 000000", outs()); end
    areset = 1'b0;
    send_end(2);
    checks++;
    if (outs() !== 6'b010000) begin errors++; $display("FAIL end_after_reset got %b want 010000", outs()); end
  endtask

  task automatic test_ambiguous();
    logic [3:0] seq_a[5] = '{A_N | B_N, B_N, B_N, A_P, B_P};
    logic [3:0] seq_b[5] = '{A_N | B_N, A_N, A_N, B_P, A_P};
    for (int i = 0; i < 5; i++) begin
      step(seq_a[i]);
      checks++;
      if (outs() !== 6'b000000) begin errors++; $display("FAIL ambiguous_a%0d got %b want 000000", i, outs()); end
    end
    for (int i = 0; i < 5; i++) begin
      step(seq_b[i]);
      checks++;
      if (outs() !== 6'b000000) begin errors++; $display("FAIL ambiguous_b%0d got %b want 000000", i, outs()); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    send_start(4);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL en_pre_start got %b want 100001", outs()); end
    en = 1'b0;
    step(A_N);
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? B_N : A_P);
      checks++;
      if (outs() !== 6'b000000) begin errors++; $display("FAIL en_low_step%0d got %b want 000000", i, outs()); end
    end
    en = 1'b1;
    send_start(4);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL en_reenable got %b want 100001", outs()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_start(4);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL b2b_start got %b want 100001", outs()); end
    send_end(2);
    checks++;
    if (outs() !== 6'b010000) begin errors++; $display("FAIL b2b_end got %b want 010000", outs()); end
    // Counted strobe coincident with close: neither counted nor an opening.
    step(A_N);
    for (int i = 0; i < 4; i++) step(B_N);
    step(A_P | B_N);
    checks++;
    if (outs() !== 6'b100001) begin errors++; $display("FAIL coincident_close got %b want 100001", outs()); end
    step(A_N);
    step(A_N);
    step(B_P);
    checks++;
    if (outs() !== 6'b000001) begin errors++; $display("FAIL coincident_open got %b want 000001", outs()); end
    step(A_P);
    checks++;
    if (outs() !== 6'b000001) begin errors++; $display("FAIL coincident_cleanup got %b want 000001", outs()); end
  endtask

  task automatic test_random();
    logic m_inf;
    int kind, n, sat;
    bit co;
    logic [4:0] pulse;
    do_reset();
    m_inf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 1);
      n    = $urandom_range(0, 6);
      co   = ($urandom_range(0, 3) == 0);
      step(kind == 0 ? A_N : B_N);
      for (int i = 0; i < n; i++) begin
        step(kind == 0 ? B_N : A_N);
        repeat ($urandom_range(0, 2)) step(NONE);
        checks++;
        if (outs() !== {5'b00000, m_inf}) begin
          errors++;
          $display("FAIL rand_inwin it%0d got %b want %b", it, outs(), {5'b00000, m_inf});
        end
      end
      if (kind == 0) step(co ? (A_P | B_N) : A_P);
      else step(co ? (B_P | A_N) : B_P);
      // Reference: classify the clipped pulse count against the pattern rules.
      sat   = (n > MAXC) ? MAXC : n;
      pulse = 5'b00000;
      if (sat >= 2) begin
        if (kind == 0) begin
          pulse = (sat == 4) ? 5'b10000 : 5'b00100;
          m_inf = (sat == 4);
        end else begin
          pulse = (sat == 2) ? 5'b01000 : 5'b00010;
          m_inf = 1'b0;
        end
      end
      checks++;
      if (outs() !== {pulse, m_inf}) begin
        errors++;
        $display("FAIL rand_close it%0d kind%0d n%0d co%0d got %b want %b", it, kind, n, co, outs(), {pulse, m_inf});
      end
      step(NONE);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_ignore_and_errors();
    test_timeout();
    test_saturation();
    test_reset_mid_window();
    test_ambiguous();
    test_enable();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maple_frame_pattern_decoder.md
# maple_frame_pattern_decoder

Parametrised Maple bus framing decoder detecting both the start pattern (SDCKA held low while SDCKB pulses START_PULSES times) and the end pattern (SDCKB held low while SDCKA pulses END_PULSES times). It sits in the receive path beside the bit deserialiser, consumes single-cycle edge strobes from the line synchronisers and emits one-cycle frame event pulses, an error pulse per malformed pattern, a watchdog timeout and an in-frame level.

## Interface
- START_PULSES, 4: SDCKB falling edges required inside an SDCKA-low window for a valid start.
- END_PULSES, 2: SDCKA falling edges required inside an SDCKB-low window for a valid end.
- IGNORE_BELOW, 2: window pulse counts below this are normal data activity; silently discarded.
- CNT_W, 8: pulse counter width; counter saturates at 2^CNT_W-1.
- TIMEOUT, 1024: max aclk cycles a window may stay open; 0 disables the watchdog.
- TO_W, 16: watchdog counter width; TIMEOUT must be < 2^TO_W.
- aclk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- en  in  1  decoder enable; low forces IDLE and clears counters.
- sdcka_posedge, sdcka_negedge  in  1 each  one-cycle edge strobes for SDCKA.
- sdckb_posedge, sdckb_negedge  in  1 each  one-cycle edge strobes for SDCKB.
- start_frame  out  1  one-cycle pulse, valid start pattern.
- end_frame  out  1  one-cycle pulse, valid end pattern.
- start_error  out  1  one-cycle pulse, malformed start window.
- end_error  out  1  one-cycle pulse, malformed end window.
- timeout  out  1  one-cycle pulse, window exceeded TIMEOUT.
- in_frame  out  1  level, high between accepted start and end/error/timeout.

## Operation
- Reset: state IDLE, counters 0, all outputs 0; takes effect immediately, mid-window included.
- States: IDLE, START_WIN, END_WIN (one-hot).
- IDLE: sdcka_negedge alone -> START_WIN; sdckb_negedge alone -> END_WIN; both in same cycle -> stay IDLE (ambiguous, no output).
- On window entry pulse counter and watchdog clear to 0.
- START_WIN: each sdckb_negedge increments counter (saturating). Closing strobe sdcka_posedge -> IDLE.
- END_WIN: each sdcka_negedge increments counter (saturating). Closing strobe sdckb_posedge -> IDLE.
- Counted strobe coincident with closing strobe: not counted.
- Close classification, count N, expected E: N < IGNORE_BELOW -> nothing; N == E -> start_frame/end_frame; otherwise (IGNORE_BELOW <= N != E, including saturated) -> start_error/end_error.
- Watchdog: increments every cycle in a window; reaching TIMEOUT without close -> timeout pulse, IDLE, no start/end classification that cycle. Closing strobe in the same cycle as expiry: closing wins, no timeout.
- in_frame: set with start_frame; cleared with end_frame, any error, or timeout. start_frame while already in_frame: stays high (resync, no error). end_frame while not in_frame: still pulses.
- en low: state IDLE, counters 0, in_frame 0, no pulses; strobes ignored.
- At most one of start_frame/end_frame/start_error/end_error/timeout high in any cycle.

## Timing
- All outputs registered; event pulses appear exactly 1 aclk cycle after the cycle sampling the closing strobe (or watchdog expiry), high for one cycle.
- in_frame changes in the same cycle as the corresponding pulse.
- Back-to-back: a new opening strobe is accepted the cycle after the closing strobe (state returns to IDLE in one cycle); opening strobe coincident with closing strobe is not seen.
- Watchdog expiry: window entered at cycle t, no close -> timeout high at cycle t+TIMEOUT+1.

## Test plan
- Default params: A negedge, 4 B negedges, A posedge -> start_frame one cycle after A posedge, in_frame 1; then B negedge, 2 A negedges, B posedge -> end_frame, in_frame 0.
- End window with 0 and 1 A negedges -> no outputs; with 3 -> end_error, in_frame cleared; start window with 2, 3, 5 B negedges -> start_error each.
- START_WIN open with no close, TIMEOUT=16 -> timeout exactly 17 cycles after entry, state IDLE; close on expiry cycle -> classification, no timeout.
- 300 counted strobes with CNT_W=8 -> counter saturates at 255, close gives error, no wrap to valid count.
- areset asserted mid END_WIN with count 1, then valid end sequence -> outputs 0 during reset, end_frame afterwards; sdcka_negedge+sdckb_negedge same cycle in IDLE -> no window opened.
- en low during valid start sequence -> no pulses, in_frame 0; re-enable and repeat -> start_frame.
